// File: rtl/seven_seg_display.sv
// Binary (0..2047) to 4-digit multiplexed common-anode seven-segment driver.
// Latency: 13 edges from a new value to seg; no backpressure, input changes mid-conversion are caught by the next IDLE compare.
module seven_seg_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        gameClk,
    input  logic        rst,
    input  logic [10:0] number_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        conv_busy,
    output logic        conv_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [10:0] bin_sr_q, bin_sr_d;
    logic [10:0] latched_q, latched_d;
    logic [10:0] last_value_q, last_value_d;
    logic [15:0] bcd_sr_q, bcd_sr_d;
    logic [15:0] digit_reg_q, digit_reg_d;
    logic [15:0] bcd_adj;
    logic [3:0]  bit_cnt_q, bit_cnt_d;

    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       cur_digit;
    logic             blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd_sr_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bin_sr_d     = bin_sr_q;
        latched_d    = latched_q;
        last_value_d = last_value_q;
        bcd_sr_d     = bcd_sr_q;
        digit_reg_d  = digit_reg_q;
        bit_cnt_d    = bit_cnt_q;
        conv_busy    = 1'b0;
        conv_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (number_in != last_value_q) begin
                    bin_sr_d  = number_in;
                    latched_d = number_in;
                    bcd_sr_d  = 16'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                conv_busy              = 1'b1;
                {bcd_sr_d, bin_sr_d}   = {bcd_adj, bin_sr_q} << 1;
                bit_cnt_d              = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd10) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                conv_busy    = 1'b1;
                conv_done    = 1'b1;
                digit_reg_d  = bcd_sr_q;
                last_value_d = latched_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        digit_sel_d   = digit_sel_q;
        if (refresh_cnt_q == CNT_MAX) begin
            refresh_cnt_d = '0;
            digit_sel_d   = digit_sel_q + 2'd1;
        end
        cur_digit = digit_reg_q[{digit_sel_q, 2'b00} +: 4];
        case (digit_sel_q)
            2'd1:    blank = (digit_reg_q[15:4] == 12'd0);
            2'd2:    blank = (digit_reg_q[15:8] == 8'd0);
            2'd3:    blank = (digit_reg_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && BLANK_LZ;
        seg_d = blank ? 7'b1111111 : decode(cur_digit);
        an_d  = ~(4'b0001 << digit_sel_q);
    end

    always_ff @(posedge gameClk) begin
        if (rst) begin
            state_q       <= IDLE;
            bin_sr_q      <= 11'd0;
            latched_q     <= 11'd0;
            last_value_q  <= 11'd0;
            bcd_sr_q      <= 16'd0;
            digit_reg_q   <= 16'd0;
            bit_cnt_q     <= 4'd0;
            refresh_cnt_q <= '0;
            digit_sel_q   <= 2'd0;
            seg_q         <= 7'b1111111;
            an_q          <= 4'b1111;
        end else begin
            state_q       <= state_d;
            bin_sr_q      <= bin_sr_d;
            latched_q     <= latched_d;
            last_value_q  <= last_value_d;
            bcd_sr_q      <= bcd_sr_d;
            digit_reg_q   <= digit_reg_d;
            bit_cnt_q     <= bit_cnt_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_sel_q   <= digit_sel_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule

// File: doc/seven_seg_display.md
Name: seven_seg_display

Overview:
- Consumer end of the game's `number_to_display` path: takes the 11-bit binary value (0..2047) and shows it as 4 decimal digits on the board's multiplexed, common-anode seven-segment display.
- Converts binary to BCD with an iterative shift-add-3 FSM, holds the converted digits, and scans the four anodes at a parameterised refresh rate.
- Sits between the display-select logic and the top-level seg/an pins.

Parameters:
- REFRESH_DIV, 50000, gameClk cycles each digit is held before the scan advances (min 1).
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 never blanked); 0 = show all four digits.

Ports:
- gameClk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- number_in  input  11  binary value to display, 0..2047
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active low, registered
- an  output  4  digit anodes, an[0] = units, active low, registered
- dp  output  1  decimal point, active low; constant 1 (off)
- conv_busy  output  1  high while a conversion is in SHIFT or DONE
- conv_done  output  1  one-cycle pulse when new digits are committed

Behaviour:
- Reset (rst sampled high at an edge) sets:
  - seg=7'b1111111, an=4'b1111, dp=1, conv_busy=0, conv_done=0.
  - last_value=0, digit_reg={0,0,0,0}, refresh_cnt=0, digit_sel=0, FSM=IDLE.
- Reset mid-conversion aborts the conversion; digit_reg returns to zeros.
- FSM IDLE:
  - Each edge, compare number_in with last_value.
  - If they differ: latch number_in into bin_sr, clear bcd_sr (16 bits), clear bit_cnt, go to SHIFT.
  - Otherwise stay in IDLE.
- FSM SHIFT, 11 edges:
  - Each edge, add 3 to every BCD nibble that is >= 5, then shift {bcd_sr, bin_sr} left by 1.
  - bit_cnt increments; after the 11th shift, go to DONE.
- FSM DONE, 1 edge:
  - digit_reg <= bcd_sr, last_value <= latched value.
  - conv_done=1 for this cycle only; return to IDLE.
- Latency: with number_in sampled at the IDLE edge E0, shifts occur at E1..E11 and the commit at E12. New digits appear on seg from E13.
- conv_busy is high from the edge after E0 through E12 inclusive.
- number_in changes during SHIFT/DONE are ignored. The next IDLE compare catches them, so the display always converges to the final stable value. Intermediate values may be skipped.
- Input range: thousands digit is 0..2. Values are never clamped.
- Scan:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap, digit_sel advances 0->1->2->3->0.
  - Every edge out of reset, an <= ~(1<<digit_sel) and seg <= decode(digit_reg[digit_sel]).
- Decode, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble >9 (unreachable) = 1111111
- Blanking with BLANK_LZ=1: digit i (i>0) shows seg=1111111 when it and every higher digit are 0. an still strobes that position. Blanking is evaluated from digit_reg only.
- The scan runs independently of the FSM. Digit commit and scan advance on the same edge are both legal; the next edge decodes from the new digit_reg.

Test Plan:
1. Assert rst 2 cycles, release, number_in=0 -> seg=1111111, an=1111 during reset. One edge after release: an=1110, seg=1000000. conv_busy stays 0.
2. REFRESH_DIV=4, number_in 0->2047 at E0 -> conv_busy high E1..E12, conv_done pulse at E12, digit_reg={2,0,4,7}. Scan shows units 7 (1111000), tens 4, hundreds 0 (1000000, not blanked), thousands 2 (0100100), each for 4 cycles, an cycling 1110,1101,1011,0111.
3. BLANK_LZ=1, number_in=5 -> units 0010010. Tens, hundreds and thousands all seg=1111111 while their anodes strobe. Repeat with BLANK_LZ=0 -> those digits show 1000000.
4. number_in=100, then changed to 1234 at E5 mid-SHIFT -> first commit shows {0,1,0,0}. A second conversion starts at the next IDLE edge and commits {1,2,3,4} 13 edges later. Exactly two conv_done pulses.
5. number_in=999 with rst asserted at SHIFT cycle 6 -> after reset digit_reg=0, display shows 0. FSM re-converts 999 from IDLE and commits {0,9,9,9} 13 edges after release.
6. Hold number_in=2047 for 100 cycles after commit -> no further conv_busy or conv_done activity; seg/an scan continues unchanged.
